// File: rtl/debounce_scan_ctrl.sv
// rtl/debounce_scan_ctrl.sv - shared-engine multi-channel debouncer with event FIFO
// Optional auto-repeat events are built when DEBOUNCE_REPEAT_EN is defined.
module debounce_scan_ctrl #(
    parameter int NUM_CH       = 4,
    parameter int TICK_DIV     = 16,
    parameter int STABLE_TICKS = 8,
    parameter int FIFO_DEPTH   = 4
`ifdef DEBOUNCE_REPEAT_EN
    ,
    parameter int REPEAT_TICKS = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire               VPWR,
    inout  wire               VGND,
    input  logic [NUM_CH-1:0] buttons,
    input  logic              enable,
    output logic [NUM_CH-1:0] state,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [2:0]        evt_ch,
    output logic              evt_level,
    output logic              evt_repeat,
    output logic              overflow,
    input  logic              clear_ovf
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} fsm_t;

    wire unused_rails = ^{VPWR, VGND};

    logic [NUM_CH-1:0] sync1, sync2;
    logic [PRE_W-1:0]  pres;
    fsm_t              fsm;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        cnt [NUM_CH];

    logic       tick, scanning, cur_sync, cur_state, mismatch, commit, rpt_fire;
    logic       push_req, push_ok, push_level, pop, full;
    logic [3:0] cnt_next;

    assign tick      = enable && (pres == PRE_W'(TICK_DIV - 1));
    assign scanning  = enable && (fsm == SCAN);
    assign cur_sync  = sync2[idx];
    assign cur_state = state[idx];
    assign mismatch  = cur_sync != cur_state;
    assign cnt_next  = cnt[idx] + 4'd1;
    assign commit    = scanning && mismatch && (cnt_next == 4'(STABLE_TICKS));

`ifdef DEBOUNCE_REPEAT_EN
    logic [5:0] hold [NUM_CH];
    logic [5:0] hold_next;
    assign hold_next = hold[idx] + 6'd1;
    assign rpt_fire  = scanning && cur_state && !commit && (hold_next == 6'(REPEAT_TICKS));
`else
    assign rpt_fire  = 1'b0;
`endif

    // A commit flips the level; a repeat only fires while held, so both cases reduce to this.
    assign push_level = commit ^ cur_state;
    assign push_req   = commit || rpt_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            pres  <= '0;
            fsm   <= IDLE;
            idx   <= '0;
            state <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
`ifdef DEBOUNCE_REPEAT_EN
                hold[i] <= '0;
`endif
            end
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
            if (!enable) begin
                pres <= '0;
                fsm  <= IDLE;
                idx  <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt[i] <= '0;
`ifdef DEBOUNCE_REPEAT_EN
                    hold[i] <= '0;
`endif
                end
            end else begin
                pres <= tick ? '0 : pres + PRE_W'(1);
                case (fsm)
                    IDLE: begin
                        if (tick) begin
                            fsm <= SCAN;
                            idx <= '0;
                        end
                    end
                    SCAN: begin
                        if (!mismatch) begin
                            cnt[idx] <= '0;
                        end else if (commit) begin
                            state[idx] <= ~cur_state;
                            cnt[idx]   <= '0;
                        end else begin
                            cnt[idx] <= cnt_next;
                        end
`ifdef DEBOUNCE_REPEAT_EN
                        if (!cur_state || commit || rpt_fire)
                            hold[idx] <= '0;
                        else
                            hold[idx] <= hold_next;
`endif
                        if (idx == IDX_W'(NUM_CH - 1))
                            fsm <= DONE;
                        else
                            idx <= idx + IDX_W'(1);
                    end
                    DONE:    fsm <= IDLE;
                    default: fsm <= IDLE;
                endcase
            end
        end
    end

    logic [4:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [2:0]       head_ch;
    logic             head_level, head_rep;

    assign evt_valid = count != '0;
    assign full      = count == CNT_W'(FIFO_DEPTH);
    assign pop       = evt_valid && evt_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {3'(idx), push_level, rpt_fire};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;
        end
    end

    assign {head_ch, head_level, head_rep} = mem[rd_ptr];
    assign evt_ch    = evt_valid ? head_ch : 3'd0;
    assign evt_level = evt_valid && head_level;
`ifdef DEBOUNCE_REPEAT_EN
    assign evt_repeat = evt_valid && head_rep;
`else
    wire unused_rpt = head_rep;
    assign evt_repeat = 1'b0;
`endif

endmodule
